iomem_bellek_yanitlayici: RTL and testbench

Responder (slave) end of the iomem valid/ready bus, which the processor's main-memory controller drives as initiator. It is a word-organised on-chip SRAM with byte write strobes, an address window decode, and programmable read/write wait states. It serves as the bench and FPGA memory model behind the processor's iomem port. Out-of-window accesses complete with an error data word, so the initiator can never hang.

---
 rtl/iomem_bellek_yanitlayici.sv | 181 ++++++++++++++++++
 tb/tb_iomem_bellek_yanitlayici.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/iomem_bellek_yanitlayici.sv
// iomem valid/ready responder: word SRAM with byte strobes, window decode, programmable wait states.
// Optional IOMEM_HATA_SAYACI_EN adds hata_sayisi_o, a saturating count of out-of-window completions.
module iomem_bellek_yanitlayici #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          ADR_BIT    = 10,
  parameter int          READ_WAIT  = 2,
  parameter int          WRITE_WAIT = 1,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata
`ifdef IOMEM_HATA_SAYACI_EN
  ,
  output logic [15:0] hata_sayisi_o
`endif
);

  localparam int DEPTH = 1 << ADR_BIT;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    BEKLE = 2'd1,
    YANIT = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [3:0]         cnt_r;
  logic [3:0]         cnt_next_s;
  logic [ADR_BIT-1:0] idx_r;
  logic [3:0]         wstrb_r;
  logic [31:0]        wdata_r;
  logic               in_win_r;
  logic               ready_r;
  logic [31:0]        rdata_r;

  logic               in_win_s;
  logic [ADR_BIT-1:0] idx_s;
  logic [3:0]         wait_s;
  logic               cur_in_win_s;
  logic [ADR_BIT-1:0] cur_idx_s;
  logic               cur_wr_s;
  logic [31:0]        resp_s;
  logic [1:0]         unused_addr_s;

  logic [31:0] mem [DEPTH];

  assign unused_addr_s = iomem_addr[1:0];
  assign iomem_ready   = ready_r;
  assign iomem_rdata   = rdata_r;

  // Window decode and wait-state selection for the request on the bus
  always_comb begin
    in_win_s = (iomem_addr[31:ADR_BIT+2] == BASE_ADDR[31:ADR_BIT+2]);
    idx_s    = iomem_addr[ADR_BIT+1:2];
    if (!in_win_s) begin
      wait_s = 4'd0;
    end else if (iomem_wstrb != 4'b0000) begin
      wait_s = 4'(WRITE_WAIT);
    end else begin
      wait_s = 4'(READ_WAIT);
    end
  end

  // Next-state and wait counter logic
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      BOSTA: begin
        if (iomem_valid) begin
          cnt_next_s   = wait_s;
          state_next_s = (wait_s == 4'd0) ? YANIT : BEKLE;
        end else begin
          state_next_s = BOSTA;
        end
      end
      BEKLE: begin
        cnt_next_s = cnt_r - 4'd1;
        // A zero count here is unreachable; finish rather than wrap around
        if (cnt_r <= 4'd1) begin
          state_next_s = YANIT;
        end else begin
          state_next_s = BEKLE;
        end
      end
      YANIT: begin
        state_next_s = BOSTA;
        cnt_next_s   = 4'd0;
      end
      default: begin
        state_next_s = BOSTA;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // Response word: a zero-wait request enters YANIT straight from the bus, otherwise from the latch
  always_comb begin
    if (state_r == BOSTA) begin
      cur_in_win_s = in_win_s;
      cur_idx_s    = idx_s;
      cur_wr_s     = (iomem_wstrb != 4'b0000);
    end else begin
      cur_in_win_s = in_win_r;
      cur_idx_s    = idx_r;
      cur_wr_s     = (wstrb_r != 4'b0000);
    end
    if (cur_wr_s) begin
      resp_s = 32'h0000_0000;
    end else if (!cur_in_win_s) begin
      resp_s = ERR_DATA;
    end else begin
      resp_s = mem[cur_idx_s];
    end
  end

  // State, counter and registered bus outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= BOSTA;
      cnt_r   <= 4'd0;
      ready_r <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      ready_r <= (state_next_s == YANIT);
      if ((state_next_s == YANIT) && (state_r != YANIT)) begin
        rdata_r <= resp_s;
      end
    end
  end

  // Request latch on the accepting edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_r    <= '0;
      wstrb_r  <= 4'b0000;
      wdata_r  <= 32'h0000_0000;
      in_win_r <= 1'b0;
    end else if ((state_r == BOSTA) && iomem_valid) begin
      idx_r    <= idx_s;
      wstrb_r  <= iomem_wstrb;
      wdata_r  <= iomem_wdata;
      in_win_r <= in_win_s;
    end
  end

  // Byte-strobed write commit at the edge that ends YANIT; reset forces BOSTA so aborts never commit
  always_ff @(posedge clk_i) begin
    if ((state_r == YANIT) && in_win_r) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_r[i]) begin
          mem[idx_r][8*i +: 8] <= wdata_r[8*i +: 8];
        end
      end
    end
  end

`ifdef IOMEM_HATA_SAYACI_EN
  logic [15:0] hata_r;
  assign hata_sayisi_o = hata_r;

  // Saturating count of out-of-window completions
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hata_r <= 16'h0000;
    end else if ((state_r == YANIT) && !in_win_r && (hata_r != 16'hFFFF)) begin
      hata_r <= hata_r + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_iomem_bellek_yanitlayici.sv
// Directed self-checking bench for iomem_bellek_yanitlayici (default parameters).
module tb_iomem_bellek_yanitlayici;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic [31:0] iomem_rdata;
`ifdef IOMEM_HATA_SAYACI_EN
  logic [15:0] hata_sayisi;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  iomem_bellek_yanitlayici dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata)
`ifdef IOMEM_HATA_SAYACI_EN
    ,
    .hata_sayisi_o(hata_sayisi)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // lat = edges after the accepting edge until ready is seen (equals the wait count W)
  task automatic txn(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] rd, output int lat);
    lat = 0;
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = a;
    iomem_wstrb = s;
    iomem_wdata = d;
    @(posedge clk); #1;
    while (!iomem_ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ready_seen", {31'd0, iomem_ready}, 32'd1);
    rd = iomem_rdata;
    @(negedge clk);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
  endtask

  task automatic count_ready(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (iomem_ready) n++;
    end
  endtask

  initial begin
    logic [31:0] rd;
    int lat;
    int n;
    int k;

    // 1: reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, iomem_ready}, 32'd0);
    check("rst_rdata", iomem_rdata, 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    count_ready(10, n);
    check("idle_no_ready", n, 32'd0);
    check("idle_rdata", iomem_rdata, 32'h0);

    // 2: full write then read
    txn(32'h4000_0010, 4'hF, 32'h1122_3344, rd, lat);
    check("wr_lat", lat, 32'd1);
    check("wr_rdata", rd, 32'h0);
    txn(32'h4000_0010, 4'h0, 32'h0, rd, lat);
    check("rd_lat", lat, 32'd2);
    check("rd_data", rd, 32'h1122_3344);

    // 3: single-byte strobe
    txn(32'h4000_0010, 4'h2, 32'hAABB_CCDD, rd, lat);
    check("wr2_lat", lat, 32'd1);
    txn(32'h4000_0010, 4'h0, 32'h0, rd, lat);
    check("rd2_data", rd, 32'h1122_CC44);

    // 4: out of window
    txn(32'h5000_0000, 4'h0, 32'h0, rd, lat);
    check("oow_rd_lat", lat, 32'd0);
    check("oow_rd_data", rd, 32'hDEAD_BEEF);
    txn(32'h5000_0010, 4'hF, 32'hFFFF_FFFF, rd, lat);
    check("oow_wr_lat", lat, 32'd0);
    check("oow_wr_rdata", rd, 32'h0);
    txn(32'h4000_0010, 4'h0, 32'h0, rd, lat);
    check("rd3_data", rd, 32'h1122_CC44);
`ifdef IOMEM_HATA_SAYACI_EN
    check("hata_sayisi", {16'd0, hata_sayisi}, 32'd2);
`endif

    // 5: back-to-back with valid held high
    txn(32'h4000_0020, 4'hF, 32'h5566_7788, rd, lat);
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h4000_0010;
    iomem_wstrb = 4'h0;
    k = 0;
    @(posedge clk); #1;
    while (!iomem_ready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("b2b_ready1", {31'd0, iomem_ready}, 32'd1);
    check("b2b_data1", iomem_rdata, 32'h1122_CC44);
    k = 0;
    @(posedge clk); #1;
    k = 1;
    check("b2b_idle", {31'd0, iomem_ready}, 32'd0);
    @(negedge clk);
    iomem_addr = 32'h4000_0020;
    while (!iomem_ready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("b2b_gap", k, 32'd4);
    check("b2b_data2", iomem_rdata, 32'h5566_7788);
    @(negedge clk);
    iomem_valid = 1'b0;

    // 6: reset during BEKLE aborts the write
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h4000_0010;
    iomem_wstrb = 4'hF;
    iomem_wdata = 32'h0;
    @(posedge clk); #1;
    rst_ni = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    #1;
    check("abort_ready", {31'd0, iomem_ready}, 32'd0);
    check("abort_rdata", iomem_rdata, 32'h0);
    count_ready(2, n);
    check("abort_rst_ready", n, 32'd0);
    rst_ni = 1'b1;
    count_ready(5, n);
    check("abort_no_ready", n, 32'd0);
    txn(32'h4000_0010, 4'h0, 32'h0, rd, lat);
    check("abort_rd_lat", lat, 32'd2);
    check("abort_rd_data", rd, 32'h1122_CC44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
